// File: rtl/mux_port_arbiter_pkg.sv
// Shared constants and helpers for the three-way mux port arbiter.
package mux_port_arbiter_pkg;

    localparam int NUM_REQ = 3;

    // Mux select encoding: owner index, or 11 when no one owns the mux
    localparam logic [1:0] SEL_IN1  = 2'b00;
    localparam logic [1:0] SEL_IN2  = 2'b01;
    localparam logic [1:0] SEL_IN3  = 2'b10;
    localparam logic [1:0] SEL_IDLE = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // Requester index reached by stepping 'step' places past 'base', modulo 3
    function automatic logic [1:0] rr_idx(input logic [1:0] base, input int unsigned step);
        int unsigned sum;
        sum = {30'd0, base} + step;
        return 2'(sum % 32'd3);
    endfunction

endpackage

// File: rtl/mux_port_arbiter_rr_pick3.sv
// Combinational round-robin picker over three requesters.
// Searches last+1, last+2, last+3 (mod 3); an optional index is skipped.
module rr_pick3
    import mux_port_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    input  logic       exclude_valid,
    input  logic [1:0] exclude_idx,
    output logic       valid,
    output logic [1:0] idx
);

    logic [1:0] cand;

    // First asserted, non-excluded requester in rotating priority order wins
    always_comb begin
        valid = 1'b0;
        idx   = 2'd0;
        cand  = 2'd0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = rr_idx(last, k);
            if (!valid && req[cand] && !(exclude_valid && (exclude_idx == cand))) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_port_arbiter.sv
// Round-robin arbiter for a shared three-input datapath mux with a bounded
// hold time. All outputs come straight from registers.
module mux_port_arbiter
    import mux_port_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    output logic [2:0] grant,
    output logic [1:0] select,
    output logic       busy,
    output logic       preempt
);

    // Counter saturation point; with the timeout disabled it just pins at all-ones
    localparam logic [CNT_W-1:0] CNT_SAT = (MAX_HOLD == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD - 1);

    arb_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       last_owner, last_n;
    logic [2:0]       grant_n;
    logic [1:0]       select_n;
    logic             busy_n, preempt_n;

    logic             pick_valid;
    logic [1:0]       pick_idx;
    logic             owner_req, others_req, timeout;

    // In GRANT the owner is last_owner and grant is its one-hot
    assign owner_req  = |(req & grant);
    assign others_req = |(req & ~grant);
    assign timeout    = (MAX_HOLD != 0) && (state == ST_GRANT) && (cnt == CNT_SAT)
                        && owner_req && others_req;

    rr_pick3 u_pick (
        .req           (req),
        .last          (last_owner),
        .exclude_valid (state == ST_GRANT),
        .exclude_idx   (last_owner),
        .valid         (pick_valid),
        .idx           (pick_idx)
    );

    // Next-state and next-output decode; every hand-off restarts the hold counter
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        last_n    = last_owner;
        grant_n   = grant;
        select_n  = select;
        busy_n    = busy;
        preempt_n = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_n  = ST_GRANT;
                    grant_n  = 3'b001 << pick_idx;
                    select_n = pick_idx;
                    busy_n   = 1'b1;
                    cnt_n    = '0;
                    last_n   = pick_idx;
                end
            end
            ST_GRANT: begin
                if (!owner_req || timeout) begin
                    if (pick_valid) begin
                        grant_n   = 3'b001 << pick_idx;
                        select_n  = pick_idx;
                        cnt_n     = '0;
                        last_n    = pick_idx;
                        preempt_n = timeout;
                    end else begin
                        state_n  = ST_IDLE;
                        grant_n  = 3'b000;
                        select_n = SEL_IDLE;
                        busy_n   = 1'b0;
                        cnt_n    = '0;
                    end
                end else if (cnt != CNT_SAT) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n  = ST_IDLE;
                grant_n  = 3'b000;
                select_n = SEL_IDLE;
                busy_n   = 1'b0;
            end
        endcase
    end

    // State and output registers; last_owner resets to 2 so requester 0 goes first
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            last_owner <= 2'd2;
            grant      <= 3'b000;
            select     <= SEL_IDLE;
            busy       <= 1'b0;
            preempt    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            last_owner <= last_n;
            grant      <= grant_n;
            select     <= select_n;
            busy       <= busy_n;
            preempt    <= preempt_n;
        end
    end

endmodule

// File: tb/tb_mux_port_arbiter.sv
// Bench for mux_port_arbiter: four instances (MAX_HOLD = 4, 0, 1, 16) share
// stimulus and are compared every cycle against an owner/held-cycles model.
module tb_mux_port_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] req;

    logic [2:0] g [4];
    logic [1:0] s [4];
    logic       b [4];
    logic       p [4];

    int checks = 0;
    int errors = 0;

    // Model state per instance: owner (-1 none), cycles held, last owner, preempt
    int mh    [4] = '{4, 0, 1, 16};
    int owner [4];
    int held  [4];
    int last  [4];
    bit pre   [4];

    always #5 clk = ~clk;

    mux_port_arbiter #(.MAX_HOLD(4),  .CNT_W(5)) u_mh4  (.clk(clk), .reset(reset), .req(req),
        .grant(g[0]), .select(s[0]), .busy(b[0]), .preempt(p[0]));
    mux_port_arbiter #(.MAX_HOLD(0),  .CNT_W(5)) u_mh0  (.clk(clk), .reset(reset), .req(req),
        .grant(g[1]), .select(s[1]), .busy(b[1]), .preempt(p[1]));
    mux_port_arbiter #(.MAX_HOLD(1),  .CNT_W(5)) u_mh1  (.clk(clk), .reset(reset), .req(req),
        .grant(g[2]), .select(s[2]), .busy(b[2]), .preempt(p[2]));
    mux_port_arbiter #(.MAX_HOLD(16), .CNT_W(5)) u_mh16 (.clk(clk), .reset(reset), .req(req),
        .grant(g[3]), .select(s[3]), .busy(b[3]), .preempt(p[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Round-robin choice: first asserted index after base, never 'excl'
    function automatic int rr(input logic [2:0] r, input int base, input int excl);
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = (base + k) % 3;
            if (r[c] && c != excl) return c;
        end
        return -1;
    endfunction

    function automatic void model_step(input int d, input logic [2:0] r, input logic rst);
        int w;
        pre[d] = 1'b0;
        if (rst) begin
            owner[d] = -1; held[d] = 0; last[d] = 2;
        end else if (owner[d] < 0) begin
            w = rr(r, last[d], -1);
            if (w >= 0) begin owner[d] = w; held[d] = 1; last[d] = w; end
        end else if (!r[owner[d]]) begin
            w = rr(r, owner[d], owner[d]);
            owner[d] = w; held[d] = (w >= 0) ? 1 : 0;
            if (w >= 0) last[d] = w;
        end else begin
            w = rr(r, owner[d], owner[d]);
            if (mh[d] != 0 && held[d] >= mh[d] && w >= 0) begin
                pre[d] = 1'b1; owner[d] = w; held[d] = 1; last[d] = w;
            end else begin
                held[d]++;
            end
        end
    endfunction

    // Apply inputs for one cycle, advance the model, compare all instances
    task automatic step(input logic [2:0] r, input logic rst);
        req   = r;
        reset = rst;
        for (int d = 0; d < 4; d++) model_step(d, r, rst);
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("grant[mh=%0d]", mh[d]), 32'(g[d]),
                (owner[d] < 0) ? 32'd0 : (32'd1 << owner[d]));
            chk($sformatf("select[mh=%0d]", mh[d]), 32'(s[d]),
                (owner[d] < 0) ? 32'd3 : 32'(owner[d]));
            chk($sformatf("busy[mh=%0d]", mh[d]), 32'(b[d]), 32'(owner[d] >= 0));
            chk($sformatf("preempt[mh=%0d]", mh[d]), 32'(p[d]), 32'(pre[d]));
        end
    endtask

    initial begin
        logic [2:0] r;
        req   = 3'b000;
        reset = 1'b1;
        @(negedge clk);
        step(3'b000, 1'b1);
        step(3'b000, 1'b1);
        chk("reset_select", 32'(s[3]), 32'd3);

        // single requester: 1-cycle grant latency, idle one cycle after release
        step(3'b001, 1'b0);
        chk("tp1_grant", 32'(g[3]), 32'b001);
        for (int i = 0; i < 4; i++) step(3'b001, 1'b0);
        step(3'b000, 1'b0);
        chk("tp1_idle", 32'(s[3]), 32'd3);
        step(3'b000, 1'b0);

        // all requesting, owner drops for one cycle after 3 grant cycles
        step(3'b000, 1'b1);
        for (int i = 0; i < 16; i++) begin
            r = 3'b111;
            if (owner[3] >= 0 && held[3] == 3) r[owner[3]] = 1'b0;
            step(r, 1'b0);
        end

        // two-way contention: time-slicing / alternation / no timeout
        step(3'b000, 1'b1);
        for (int i = 0; i < 40; i++) step(3'b011, 1'b0);
        chk("tp6_nopreempt_owner", 32'(g[1]), 32'b001);

        // lone requester 2 past the hold limit, then requester 0 arrives
        step(3'b000, 1'b1);
        for (int i = 0; i < 10; i++) step(3'b100, 1'b0);
        step(3'b101, 1'b0);
        chk("tp4_handoff", 32'(g[0]), 32'b001);
        chk("tp4_preempt", 32'(p[0]), 32'd1);
        step(3'b101, 1'b0);

        // reset in the middle of a grant, then first grant goes to requester 0
        for (int i = 0; i < 5; i++) step(3'b111, 1'b0);
        step(3'b111, 1'b1);
        chk("tp5_reset_grant", 32'(g[3]), 32'd0);
        step(3'b111, 1'b0);
        chk("tp5_first", 32'(g[3]), 32'b001);

        // random traffic with sticky requests and occasional resets
        r = 3'b000;
        for (int i = 0; i < 2000; i++) begin
            for (int k = 0; k < 3; k++)
                if ($urandom_range(0, 5) == 0) r[k] = ~r[k];
            step(r, ($urandom_range(0, 299) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
